// File: rtl/m4_premult_xt2p5_a.sv
// XT2.5 M4 colour matrix, front half: shadow/active coefficient bank plus the
// nine pixel x coefficient products in a fixed two-stage pipeline.
module m4_premult_xt2p5_a #(
    parameter int unsigned PW = 16,
    parameter int unsigned CW = 15,
    parameter int unsigned OW = 31
) (
    input  logic          clk,
    input  logic          xrst,
    input  logic [PW-1:0] rin,
    input  logic [PW-1:0] gin,
    input  logic [PW-1:0] bin,
    input  logic          m4_on,
    input  logic          vs,
    input  logic          cf_wr,
    input  logic [3:0]    cf_addr,
    input  logic [CW-1:0] cf_wdata,
    output logic [CW-1:0] cf_rdata,
    output logic          cf_pend,
    output logic [OW-1:0] rr,
    output logic [OW-1:0] rg,
    output logic [OW-1:0] rb,
    output logic [OW-1:0] gr,
    output logic [OW-1:0] gg,
    output logic [OW-1:0] gb,
    output logic [OW-1:0] br,
    output logic [OW-1:0] bg,
    output logic [OW-1:0] bb,
    output logic [CW-3:0] cf0d,
    output logic [CW-3:0] cf4d,
    output logic [CW-3:0] cf8d,
    output logic [PW-1:0] rout_d,
    output logic [PW-1:0] gout_d,
    output logic [PW-1:0] bout_d,
    output logic          m4_on_d
);

    localparam int unsigned NC = 9;
    localparam int unsigned NP = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned TW = CW - 2;
    localparam logic [CW-1:0] COEF_ONE = {2'b01, {(CW-2){1'b0}}};

    // Identity matrix: unity on the diagonal entries rr, gg, bb.
    function automatic logic [CW-1:0] ident(input int unsigned idx);
        return (idx == 0 || idx == 4 || idx == 8) ? COEF_ONE : '0;
    endfunction

    // Unsigned pixel times signed coefficient; the exact product fits in OW bits.
    function automatic logic [OW-1:0] mult(input logic [PW-1:0] pix, input logic [CW-1:0] coef);
        return OW'($signed({1'b0, pix})) * OW'($signed(coef));
    endfunction

    logic [CW-1:0] shadow_q [NC];
    logic [CW-1:0] shadow_d [NC];
    logic [CW-1:0] active_q [NC];
    logic [CW-1:0] active_d [NC];
    logic          pend_q;
    logic          pend_d;
    logic [CW-1:0] rdata_q;
    logic [CW-1:0] rdata_d;
    logic          addr_ok;

    logic [PW-1:0] pix1_q [NP];
    logic [PW-1:0] pix1_d [NP];
    logic          on1_q;
    logic          on1_d;
    logic [OW-1:0] prod_q [NC];
    logic [OW-1:0] prod_d [NC];
    logic [PW-1:0] pixd_q [NP];
    logic [PW-1:0] pixd_d [NP];
    logic          ond_q;
    logic          ond_d;
    logic [TW-1:0] diag_q [NP];
    logic [TW-1:0] diag_d [NP];

    // Host side: commit uses pre-write shadow, so a write on the vs cycle stays pending.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        rdata_d  = '0;
        addr_ok  = (cf_addr < AW'(NC));
        if (vs && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end
        for (int unsigned i = 0; i < NC; i++) begin
            if (cf_addr == AW'(i)) begin
                rdata_d = shadow_q[i];
                if (cf_wr) begin
                    shadow_d[i] = cf_wdata;
                end
            end
        end
        if (cf_wr && addr_ok) begin
            pend_d = 1'b1;
        end
    end

    // Pixel side: stage 1 captures inputs, stage 2 multiplies against the active set.
    always_comb begin
        pix1_d[0] = rin;
        pix1_d[1] = gin;
        pix1_d[2] = bin;
        on1_d     = m4_on;
        pixd_d    = pix1_q;
        ond_d     = on1_q;
        for (int unsigned x = 0; x < NP; x++) begin
            for (int unsigned y = 0; y < NP; y++) begin
                prod_d[x*NP+y] = mult(pix1_q[x], active_q[x*NP+y]);
            end
        end
        diag_d[0] = active_q[0][CW-1:2];
        diag_d[1] = active_q[4][CW-1:2];
        diag_d[2] = active_q[8][CW-1:2];
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int unsigned i = 0; i < NC; i++) begin
                shadow_q[i] <= ident(i);
                active_q[i] <= ident(i);
                prod_q[i]   <= '0;
            end
            for (int unsigned i = 0; i < NP; i++) begin
                pix1_q[i] <= '0;
                pixd_q[i] <= '0;
                diag_q[i] <= COEF_ONE[CW-1:2];
            end
            pend_q  <= 1'b0;
            rdata_q <= '0;
            on1_q   <= 1'b0;
            ond_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            prod_q   <= prod_d;
            pix1_q   <= pix1_d;
            pixd_q   <= pixd_d;
            diag_q   <= diag_d;
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
            on1_q    <= on1_d;
            ond_q    <= ond_d;
        end
    end

    assign cf_rdata = rdata_q;
    assign cf_pend  = pend_q;
    assign rr       = prod_q[0];
    assign rg       = prod_q[1];
    assign rb       = prod_q[2];
    assign gr       = prod_q[3];
    assign gg       = prod_q[4];
    assign gb       = prod_q[5];
    assign br       = prod_q[6];
    assign bg       = prod_q[7];
    assign bb       = prod_q[8];
    assign cf0d     = diag_q[0];
    assign cf4d     = diag_q[1];
    assign cf8d     = diag_q[2];
    assign rout_d   = pixd_q[0];
    assign gout_d   = pixd_q[1];
    assign bout_d   = pixd_q[2];
    assign m4_on_d  = ond_q;

endmodule

// File: tb/tb_m4_premult_xt2p5_a.sv
// Directed + random bench for m4_premult_xt2p5_a: a reference model predicts each
// pixel's outputs into a queue, popped when the pixel leaves stage 2.
module tb_m4_premult_xt2p5_a;

    typedef struct packed {
        logic [8:0][30:0] p;
        logic [15:0]      r;
        logic [15:0]      g;
        logic [15:0]      b;
        logic             on;
        logic [12:0]      d0;
        logic [12:0]      d4;
        logic [12:0]      d8;
    } exp_t;

    logic        clk = 1'b0;
    logic        xrst;
    logic [15:0] rin, gin, bin;
    logic        m4_on, vs, cf_wr;
    logic [3:0]  cf_addr;
    logic [14:0] cf_wdata;
    logic [14:0] cf_rdata;
    logic        cf_pend;
    logic [30:0] rr, rg, rb, gr, gg, gb, br, bg, bb;
    logic [12:0] cf0d, cf4d, cf8d;
    logic [15:0] rout_d, gout_d, bout_d;
    logic        m4_on_d;
    logic [8:0][30:0] dut_p;

    int n_vec = 0;
    int n_err = 0;
    logic [14:0] sh [9];
    logic [14:0] ac [9];
    logic        pend;
    exp_t        q [$];

    assign dut_p = {bb, bg, br, gb, gg, gr, rb, rg, rr};

    always #5 clk = ~clk;

    m4_premult_xt2p5_a dut (
        .clk(clk), .xrst(xrst), .rin(rin), .gin(gin), .bin(bin), .m4_on(m4_on),
        .vs(vs), .cf_wr(cf_wr), .cf_addr(cf_addr), .cf_wdata(cf_wdata),
        .cf_rdata(cf_rdata), .cf_pend(cf_pend),
        .rr(rr), .rg(rg), .rb(rb), .gr(gr), .gg(gg), .gb(gb), .br(br), .bg(bg), .bb(bb),
        .cf0d(cf0d), .cf4d(cf4d), .cf8d(cf8d),
        .rout_d(rout_d), .gout_d(gout_d), .bout_d(bout_d), .m4_on_d(m4_on_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:0] emul(input logic [15:0] p, input logic [14:0] c);
        longint cs;
        longint r;
        cs = c[14] ? longint'(c) - 32768 : longint'(c);
        r  = longint'(p) * cs;
        return r[30:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            sh[i] = (i == 0 || i == 4 || i == 8) ? 15'h2000 : 15'h0000;
            ac[i] = sh[i];
        end
        pend = 1'b0;
        q.delete();
    endtask

    task automatic do_reset();
        cf_wr = 1'b0;
        vs    = 1'b0;
        xrst  = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) chk($sformatf("rst_prod%0d", i), 32'(dut_p[i]), 32'h0);
        chk("rst_rout_d", 32'(rout_d), 32'h0);
        chk("rst_gout_d", 32'(gout_d), 32'h0);
        chk("rst_bout_d", 32'(bout_d), 32'h0);
        chk("rst_m4_on_d", 32'(m4_on_d), 32'h0);
        chk("rst_cf0d", 32'(cf0d), 32'h800);
        chk("rst_cf4d", 32'(cf4d), 32'h800);
        chk("rst_cf8d", 32'(cf8d), 32'h800);
        chk("rst_cf_pend", 32'(cf_pend), 32'h0);
        chk("rst_cf_rdata", 32'(cf_rdata), 32'h0);
        model_reset();
        @(negedge clk);
        xrst = 1'b1;
    endtask

    // One pixel cycle: drive, predict, clock, then compare the pixel leaving stage 2.
    task automatic step(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                        input logic on, input logic v, input logic w,
                        input logic [3:0] a, input logic [14:0] wd);
        exp_t        e;
        logic [14:0] exp_rd;
        @(negedge clk);
        rin = r; gin = g; bin = b; m4_on = on; vs = v;
        cf_wr = w; cf_addr = a; cf_wdata = wd;
        exp_rd = (a < 4'd9) ? sh[a] : 15'h0;
        if (v && pend) begin
            for (int i = 0; i < 9; i++) ac[i] = sh[i];
            pend = 1'b0;
        end
        if (w && a < 4'd9) begin
            sh[a] = wd;
            pend  = 1'b1;
        end
        for (int i = 0; i < 9; i++) begin
            case (i / 3)
                0:       e.p[i] = emul(r, ac[i]);
                1:       e.p[i] = emul(g, ac[i]);
                default: e.p[i] = emul(b, ac[i]);
            endcase
        end
        e.r = r; e.g = g; e.b = b; e.on = on;
        e.d0 = ac[0][14:2]; e.d4 = ac[4][14:2]; e.d8 = ac[8][14:2];
        q.push_back(e);
        @(posedge clk);
        #1;
        chk("cf_pend", 32'(cf_pend), 32'(pend));
        chk("cf_rdata", 32'(cf_rdata), 32'(exp_rd));
        if (q.size() > 1) begin
            e = q.pop_front();
            for (int i = 0; i < 9; i++) chk($sformatf("prod%0d", i), 32'(dut_p[i]), 32'(e.p[i]));
            chk("rout_d", 32'(rout_d), 32'(e.r));
            chk("gout_d", 32'(gout_d), 32'(e.g));
            chk("bout_d", 32'(bout_d), 32'(e.b));
            chk("m4_on_d", 32'(m4_on_d), 32'(e.on));
            chk("cf0d", 32'(cf0d), 32'(e.d0));
            chk("cf4d", 32'(cf4d), 32'(e.d4));
            chk("cf8d", 32'(cf8d), 32'(e.d8));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        xrst = 1'b1; rin = '0; gin = '0; bin = '0; m4_on = 1'b0; vs = 1'b0;
        cf_wr = 1'b0; cf_addr = '0; cf_wdata = '0;
        #2;
        do_reset();

        // Identity after reset
        step(16'h1234, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, 15'h0);
        step(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 15'h0);
        chk("id_rr", 32'(rr), 32'h2468000);
        chk("id_rg", 32'(rg), 32'h0);
        chk("id_cf0d", 32'(cf0d), 32'h800);
        chk("id_m4_on_d", 32'(m4_on_d), 32'h1);

        // Deferred commit of gr = -0.5
        step(16'h0, 16'h0100, 16'h0, 1'b1, 1'b0, 1'b1, 4'd3, 15'h7000);
        step(16'h0, 16'h0100, 16'h0, 1'b1, 1'b0, 1'b0, 4'd3, 15'h0);
        chk("defer_gr_pre", 32'(gr), 32'h0);
        chk("defer_pend_pre", 32'(cf_pend), 32'h1);
        step(16'h0, 16'h0100, 16'h0, 1'b1, 1'b1, 1'b0, 4'd3, 15'h0);
        chk("defer_pend_post", 32'(cf_pend), 32'h0);
        step(16'h0, 16'h0100, 16'h0, 1'b1, 1'b0, 1'b0, 4'd3, 15'h0);
        chk("defer_gr_post", 32'(gr), 32'h7FF00000);
        chk("defer_gg_post", 32'(gg), 32'h200000);

        // Coefficient extremes on rr
        step(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd0, 15'h3FFF);
        step(16'hFFFF, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 4'd0, 15'h0);
        step(16'hFFFF, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 4'd0, 15'h4000);
        chk("ext_rr_pos", 32'(rr), 32'h3FFEC001);
        chk("ext_cf0d_pos", 32'(cf0d), 32'hFFF);
        step(16'hFFFF, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 4'd0, 15'h0);
        step(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 15'h0);
        chk("ext_rr_neg", 32'(rr), 32'h40004000);
        chk("ext_cf0d_neg", 32'(cf0d), 32'h1000);

        // Write landing on the vs cycle stays pending
        step(16'h0100, 16'h0100, 16'h0, 1'b1, 1'b0, 1'b1, 4'd0, 15'h0000);
        step(16'h0100, 16'h0100, 16'h0, 1'b1, 1'b1, 1'b1, 4'd4, 15'h1000);
        chk("wvs_pend", 32'(cf_pend), 32'h1);
        step(16'h0100, 16'h0100, 16'h0, 1'b1, 1'b0, 1'b0, 4'd4, 15'h0);
        chk("wvs_cf0d", 32'(cf0d), 32'h0);
        chk("wvs_cf4d_hold", 32'(cf4d), 32'h800);
        chk("wvs_rr", 32'(rr), 32'h0);
        step(16'h0100, 16'h0100, 16'h0, 1'b1, 1'b1, 1'b0, 4'd4, 15'h0);
        step(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd4, 15'h0);
        chk("wvs_cf4d_new", 32'(cf4d), 32'h400);
        chk("wvs_gg_new", 32'(gg), 32'h100000);

        // Illegal address write and readback
        step(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd12, 15'h1234);
        chk("ill_pend", 32'(cf_pend), 32'h0);
        step(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd8, 15'h0);
        chk("rd_addr8", 32'(cf_rdata), 32'h2000);
        step(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd12, 15'h0);
        chk("rd_addr12", 32'(cf_rdata), 32'h0);

        // Reset in the middle of traffic with a write pending
        step(16'hABCD, 16'h1357, 16'h2468, 1'b1, 1'b0, 1'b1, 4'd1, 15'h1555);
        step(16'h4321, 16'h0F0F, 16'h7777, 1'b1, 1'b0, 1'b0, 4'd1, 15'h0);
        do_reset();
        step(16'h1234, 16'h0010, 16'h0020, 1'b1, 1'b0, 1'b0, 4'd1, 15'h0);
        chk("mid_rd_addr1", 32'(cf_rdata), 32'h0);
        step(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 15'h0);
        chk("mid_rg", 32'(rg), 32'h0);
        chk("mid_rr", 32'(rr), 32'h2468000);

        // Random traffic with writes and frame starts
        for (int k = 0; k < 40; k++) begin
            step(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), 15'($urandom));
        end
        step(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 15'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
